// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with programmable bit period and optional parity
// Registered-output FSM; every input is sampled only when a frame is accepted.
module uart_tx (
   input  logic        reset_i,
   input  logic        clock_i,
   input  logic [15:0] clock_divider_i,
   input  logic        parity_bit_i,
   input  logic        parity_even_i,
   input  logic [7:0]  data_i,
   input  logic        send_i,
   output logic        serial_o,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] reload;
   logic [2:0]  idx;
   logic [7:0]  data;
   logic        par_en;
   logic        par_even;
   logic [15:0] reload_next;

   // Divider values 0 and 1 both mean a single-cycle bit.
   assign reload_next = (clock_divider_i < 16'd2) ? 16'd0 : clock_divider_i - 16'd1;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state    <= IDLE;
         cnt      <= 16'd0;
         reload   <= 16'd0;
         idx      <= 3'd0;
         data     <= 8'd0;
         par_en   <= 1'b0;
         par_even <= 1'b0;
         serial_o <= 1'b1;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               serial_o <= 1'b1;
               busy_o   <= 1'b0;
               if (send_i) begin
                  data     <= data_i;
                  par_en   <= parity_bit_i;
                  par_even <= parity_even_i;
                  reload   <= reload_next;
                  cnt      <= reload_next;
                  state    <= START;
                  serial_o <= 1'b0;
                  busy_o   <= 1'b1;
               end
            end
            START: begin
               if (cnt == 16'd0) begin
                  cnt      <= reload;
                  idx      <= 3'd0;
                  state    <= DATA;
                  serial_o <= data[0];
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (cnt == 16'd0) begin
                  cnt <= reload;
                  if (idx == 3'd7) begin
                     if (par_en) begin
                        state    <= PARITY;
                        serial_o <= par_even ? (^data) : (~^data);
                     end else begin
                        state    <= STOP;
                        serial_o <= 1'b1;
                     end
                  end else begin
                     idx      <= idx + 3'd1;
                     serial_o <= data[idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            PARITY: begin
               if (cnt == 16'd0) begin
                  cnt      <= reload;
                  state    <= STOP;
                  serial_o <= 1'b1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (cnt == 16'd0) begin
                  cnt      <= 16'd0;
                  idx      <= 3'd0;
                  state    <= IDLE;
                  serial_o <= 1'b1;
                  busy_o   <= 1'b0;
                  done_o   <= 1'b1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state    <= IDLE;
               serial_o <= 1'b1;
               busy_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule
